vga_timing_generator: RTL
=========================

// Module: vga_timing_generator
// PURPOSE
//  Parametrised raster timing generator and successor to the fixed H/V sync pair. It produces
//  h_sync and v_sync with programmable porches and polarity, pixel and line coordinates,
//  display-enable, and line-start/frame-start strobes. It sits between the clock
//  source and the pixel pipeline; downstream blocks fetch pixels using h_count/v_count.
//  Pixel-rate enable input lets it run from a faster control_clock.
// PARAMETERS
//  COUNTER_SIZE  11    width of h_count/v_count
//  H_ACTIVE      1024  visible pixels per line
//  H_FRONT       24    h front porch (pixels)
//  H_SYNC        136   h sync pulse width (pixels)
//  H_BACK        160   h back porch (pixels); H_TOTAL = sum = 1344
//  V_ACTIVE      768   visible lines per frame
//  V_FRONT       3     v front porch (lines)
//  V_SYNC        6     v sync pulse width (lines)
//  V_BACK        29    v back porch (lines); V_TOTAL = sum = 806
//  H_SYNC_POL    0     active level of h_sync (0 = active-low)
//  V_SYNC_POL    0     active level of v_sync
// PORTS
//  control_clock   in   1             single clock, all state on rising edge
//  reset           in   1             asynchronous, active-high
//  pixel_enable    in   1             advance raster by one pixel this cycle
//  h_count         out  COUNTER_SIZE  current column, 0..H_TOTAL-1
//  v_count         out  COUNTER_SIZE  current line, 0..V_TOTAL-1
//  h_sync          out  1             horizontal sync, level per H_SYNC_POL
//  v_sync          out  1             vertical sync, level per V_SYNC_POL
//  display_enable  out  1             1 when h_count<H_ACTIVE && v_count<V_ACTIVE
//  line_start      out  1             1-cycle strobe: h_count just became 0
//  frame_start     out  1             1-cycle strobe: (h,v) just became (0,0)
// BEHAVIOUR
//  - Reset (async): h_count=H_TOTAL-1, v_count=V_TOTAL-1 (last pixel of frame);
//    h_sync/v_sync at inactive level; display_enable=0; strobes=0.
//    Consequence: the first enabled edge after reset lands on (0,0) with frame_start=1.
//  - Enabled edge (pixel_enable=1): h_count increments. At H_TOTAL-1, h_count wraps to 0 and
//    v_count increments. At V_TOTAL-1 on that same edge, v_count wraps to 0.
//  - pixel_enable=0: counts, syncs and display_enable hold. Strobes clear to 0.
//  - All outputs are registered. Decode uses next-state counts, so every output is
//    aligned with h_count/v_count in the same cycle (zero latency relative to the coordinates).
//  - h_sync active iff H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC.
//    v_sync active iff V_ACTIVE+V_FRONT <= v_count < V_ACTIVE+V_FRONT+V_SYNC.
//    The v decode depends on v_count only; it changes at h wrap.
//  - Strobes are high for exactly one control_clock cycle after the advancing edge. They
//    never stretch across stalls.
//  - Comparisons are unsigned, COUNTER_SIZE bits. Elaboration fails ($error) if H_TOTAL or
//    V_TOTAL > 2**COUNTER_SIZE, or if any of the *_SYNC/*_ACTIVE parameters is 0.
//  - Reset mid-frame: immediate return to reset values. No partial sync pulse is held.
// STRUCTURE
//  - Package vga_timing_pkg holds the XGA default localparams (H_*/V_*) and totals, plus
//    a function that returns an axis total from its four segment lengths.
//  - One sub-module, vga_axis_counter, is instantiated twice (h and v). It contains the wrap
//    counter with an advance input, a wrap output, and the registered sync/active decode.
//  - The v instance advances on pixel_enable && h_wrap.
//  - The top level combines the active flags, polarity and strobes.
// TESTING
//  1 reset, then pixel_enable=1 for 1 clk -> h=0, v=0, frame_start=1, line_start=1,
//    display_enable=1.
//  2 Run to h=1048 -> h_sync goes low that cycle and stays low 136 cycles, high at h=1184.
//    display_enable=0 from h=1024.
//  3 Run (h=1343, v=0) +1 -> h=0, v=1, line_start=1, frame_start=0.
//    At v=771 h_sync pattern repeats and v_sync=0 for lines 771..776.
//  4 Run (1343, 805) +1 -> (0,0), frame_start=1. Frame period = 1344*806 = 1083264 enabled
//    cycles, checked over 2 frames.
//  5 pixel_enable toggled 1/0 each clock -> raster advances at half rate. Strobes are 1 clk
//    wide, never 2.
//  6 Override 8/1/2/1 x 4/1/1/1 with SYNC_POL=1; assert reset mid-line -> outputs return
//    to (11,6), syncs=0 asynchronously. Full small frame matches a reference model cycle by cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults (XGA 1024x768) and axis-length helper for the
// VGA timing generator and its per-axis counters.
package vga_timing_pkg;

    localparam int XGA_COUNTER_SIZE = 11;

    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FRONT  = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BACK   = 160;

    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FRONT  = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BACK   = 29;

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int XGA_H_TOTAL = axis_total(XGA_H_ACTIVE, XGA_H_FRONT, XGA_H_SYNC, XGA_H_BACK);
    localparam int XGA_V_TOTAL = axis_total(XGA_V_ACTIVE, XGA_V_FRONT, XGA_V_SYNC, XGA_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with advance/wrap handshake and a
// registered sync decode evaluated on the next-state count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   W        = 11,
    parameter int   ACTIVE   = 1,
    parameter int   FRONT    = 1,
    parameter int   SYNC     = 1,
    parameter int   BACK     = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         active_d
);

    localparam int           TOTAL   = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    // One extra bit so a sync window ending exactly at 2**W still compares correctly.
    localparam logic [W:0]   SYNC_LO = (W+1)'(ACTIVE + FRONT);
    localparam logic [W:0]   SYNC_HI = (W+1)'(ACTIVE + FRONT + SYNC);
    localparam logic [W:0]   ACT_END = (W+1)'(ACTIVE);

    logic [W-1:0] count_d, count_q;
    logic         sync_d, sync_q;

    always_comb begin
        wrap    = advance && (count_q == LAST);
        count_d = count_q;
        if (advance) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        sync_d   = (({1'b0, count_d} >= SYNC_LO) && ({1'b0, count_d} < SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
        active_d = ({1'b0, count_d} < ACT_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= LAST;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing generator: h/v axis counters plus registered display-enable and
// line/frame start strobes, all aligned with the coordinate outputs.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int   COUNTER_SIZE = XGA_COUNTER_SIZE,
    parameter int   H_ACTIVE     = XGA_H_ACTIVE,
    parameter int   H_FRONT      = XGA_H_FRONT,
    parameter int   H_SYNC       = XGA_H_SYNC,
    parameter int   H_BACK       = XGA_H_BACK,
    parameter int   V_ACTIVE     = XGA_V_ACTIVE,
    parameter int   V_FRONT      = XGA_V_FRONT,
    parameter int   V_SYNC       = XGA_V_SYNC,
    parameter int   V_BACK       = XGA_V_BACK,
    parameter logic H_SYNC_POL   = 1'b0,
    parameter logic V_SYNC_POL   = 1'b0
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic                    pixel_enable,
    output logic [COUNTER_SIZE-1:0] h_count,
    output logic [COUNTER_SIZE-1:0] v_count,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    display_enable,
    output logic                    line_start,
    output logic                    frame_start
);

    localparam int     H_TOTAL   = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int     V_TOTAL   = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam longint COUNT_CAP = longint'(1) << COUNTER_SIZE;

    if (longint'(H_TOTAL) > COUNT_CAP || longint'(V_TOTAL) > COUNT_CAP) begin : g_size_check
        $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_zero_check
        $error("vga_timing_generator: sync and active lengths must be non-zero");
    end

    logic h_wrap, v_wrap, h_active_d, v_active_d;

    vga_axis_counter #(
        .W(COUNTER_SIZE), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT),
        .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(H_SYNC_POL)
    ) u_h_axis (
        .clk(control_clock), .rst(reset), .advance(pixel_enable),
        .count(h_count), .wrap(h_wrap), .sync(h_sync), .active_d(h_active_d)
    );

    // h_wrap already includes pixel_enable, so it is the line advance.
    vga_axis_counter #(
        .W(COUNTER_SIZE), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT),
        .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(V_SYNC_POL)
    ) u_v_axis (
        .clk(control_clock), .rst(reset), .advance(h_wrap),
        .count(v_count), .wrap(v_wrap), .sync(v_sync), .active_d(v_active_d)
    );

    logic display_enable_d, display_enable_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    always_comb begin
        display_enable_d = h_active_d && v_active_d;
        line_start_d     = h_wrap;
        frame_start_d    = h_wrap && v_wrap;
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            display_enable_q <= 1'b0;
            line_start_q     <= 1'b0;
            frame_start_q    <= 1'b0;
        end else begin
            display_enable_q <= display_enable_d;
            line_start_q     <= line_start_d;
            frame_start_q    <= frame_start_d;
        end
    end

    assign display_enable = display_enable_q;
    assign line_start     = line_start_q;
    assign frame_start    = frame_start_q;

endmodule
